// File: rtl/in_fifo_sync.sv
// rtl/in_fifo_sync.sv - single-clock first-word-fall-through input FIFO feeding a processor inport
module in_fifo_sync #(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 8,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_data_wr,
  output logic                       o_data_full,
  output logic                       o_data_almost_full,
  output logic [WIDTH-1:0]           o_inport_data,
  output logic                       o_inport_empty,
  input  logic                       i_inport_rd,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  input  logic                       i_clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LEVEL = ALMOST_FULL[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  // Flags decode the pointer registers only, never the strobes.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_count = wr_ptr - rd_ptr;

  assign wr_en = i_data_wr && !full;
  assign rd_en = i_inport_rd && !empty;

  assign o_inport_empty     = empty;
  assign o_data_full        = full;
  assign o_data_almost_full = (o_count >= AF_LEVEL);
  assign o_inport_data      = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // A dropped write outranks a same-cycle clear so no overflow event is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (i_data_wr && full) begin
      o_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in_fifo_sync.sv
// tb/tb_in_fifo_sync.sv - scoreboard bench for in_fifo_sync
module tb_in_fifo_sync;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AF    = DEPTH - 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_data_wr = 1'b0;
  logic             o_data_full;
  logic             o_data_almost_full;
  logic [WIDTH-1:0] o_inport_data;
  logic             o_inport_empty;
  logic             i_inport_rd = 1'b0;
  logic [4:0]       o_count;
  logic             o_overflow;
  logic             i_clear_overflow = 1'b0;

  in_fifo_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ALMOST_FULL(AF)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_data(i_data),
    .i_data_wr(i_data_wr),
    .o_data_full(o_data_full),
    .o_data_almost_full(o_data_almost_full),
    .o_inport_data(o_inport_data),
    .o_inport_empty(o_inport_empty),
    .i_inport_rd(i_inport_rd),
    .o_count(o_count),
    .o_overflow(o_overflow),
    .i_clear_overflow(i_clear_overflow)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  int  m_cnt = 0;
  bit  m_ovf = 1'b0;
  bit  saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [WIDTH-1:0] head;
    head = (exp_q.size() == 0) ? '0 : exp_q[0];
    chk({tag, ".count"}, 32'(o_count), 32'(m_cnt));
    chk({tag, ".empty"}, 32'(o_inport_empty), 32'(m_cnt == 0));
    chk({tag, ".full"}, 32'(o_data_full), 32'(m_cnt == DEPTH));
    chk({tag, ".afull"}, 32'(o_data_almost_full), 32'(m_cnt >= AF));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, ".data"}, 32'(o_inport_data), 32'(head));
  endtask

  // Called #1 after a rising edge: drive strobes, let one edge pass, update the model.
  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit clr);
    bit was_full;
    bit was_empty;
    i_data_wr = wr;
    i_data = d;
    i_inport_rd = rd;
    i_clear_overflow = clr;
    @(posedge i_clk);
    #1;
    was_full  = (m_cnt == DEPTH);
    was_empty = (m_cnt == 0);
    if (rd && !was_empty) m_cnt--;
    if (wr && !was_full) begin
      exp_q.push_back(d);
      m_cnt++;
    end
    if (wr && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    i_data_wr = 1'b0;
    i_inport_rd = 1'b0;
    i_clear_overflow = 1'b0;
  endtask

  // Monitor: every accepted pop is scored against the oldest expected word.
  always @(negedge i_clk) begin
    if (i_rst_n && o_data_full) saw_full = 1'b1;
    if (i_rst_n && i_inport_rd && !o_inport_empty) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(o_inport_data), 32'hDEAD);
      end else begin
        chk("pop_data", 32'(o_inport_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk_all("reset_held");
    i_rst_n = 1'b1;
    step(0, 8'h00, 0, 0);
    chk_all("idle");

    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0, 0);
      chk_all("fill");
    end

    step(1, 8'hAA, 0, 0);
    chk_all("drop_full");
    step(0, 8'h00, 0, 1);
    chk_all("clear_ovf");
    step(1, 8'hBB, 0, 1);
    chk_all("clear_vs_drop");
    step(0, 8'h00, 0, 1);
    chk_all("clear_again");

    step(1, 8'hCC, 1, 0);
    chk_all("rw_full");

    while (m_cnt > 5) begin
      step(0, 8'h00, 1, 0);
      chk_all("drain_to5");
    end
    step(1, 8'h77, 1, 0);
    chk_all("rw_at5");

    while (m_cnt > 0) begin
      step(0, 8'h00, 1, 0);
      chk_all("drain");
    end
    step(0, 8'h00, 1, 0);
    chk_all("rd_empty");
    step(1, 8'h3C, 1, 0);
    chk_all("rw_empty");
    step(0, 8'h00, 1, 0);
    chk_all("pop_3c");

    saw_full = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1, 8'(8'h40 + i), i > 0, 0);
      chk_all("stream");
    end
    step(0, 8'h00, 1, 0);
    chk_all("stream_end");
    chk("stream_no_full", 32'(saw_full), 32'd0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0, ($urandom % 8) == 0);
      chk_all("random");
    end
    while (m_cnt > 0) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    chk_all("random_drained");

    for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), 0, 0);
    chk_all("pre_reset");
    @(negedge i_clk);
    i_rst_n = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    #1;
    chk_all("async_reset");
    @(posedge i_clk);
    #1;
    chk_all("reset_edge");
    i_rst_n = 1'b1;
    step(1, 8'h5A, 0, 0);
    chk_all("post_reset_wr");
    step(0, 8'h00, 1, 0);
    chk_all("post_reset_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/in_fifo_sync.md
# in_fifo_sync

Single-clock input FIFO that carries bytes from an external producer into a 9x8 processor inport. It is the inbound counterpart of the output FIFO peripheral. An external block pushes words with a write strobe. The processor samples the head word and its empty flag through inports and pops with an inport read strobe. Both sides run on the processor clock, so no clock-domain crossing is needed.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of 2, minimum 2.
- WIDTH, 8, data word width.
- ALMOST_FULL, DEPTH-2, count at which o_data_almost_full asserts; range 1..DEPTH.

Ports:
- i_clk  in  1  processor clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous active-low reset. Assertion clears state immediately; release is synchronous to i_clk externally.
- i_data  in  WIDTH  producer write data.
- i_data_wr  in  1  producer write strobe, one word per high cycle.
- o_data_full  out  1  FIFO holds DEPTH words.
- o_data_almost_full  out  1  count >= ALMOST_FULL.
- o_inport_data  out  WIDTH  head word; 0 when empty.
- o_inport_empty  out  1  FIFO holds 0 words.
- i_inport_rd  in  1  processor pop strobe, one word per high cycle.
- o_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky flag: a write was dropped.
- i_clear_overflow  in  1  synchronous clear of o_overflow.

## Operation
- Storage: DEPTH x WIDTH register array, not reset.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits; low bits index the array and both wrap mod 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
  - o_count = wr_ptr - rd_ptr, computed mod 2^(log2(DEPTH)+1).
- Write accepted iff i_data_wr && !full, where full is the state before the edge. An accepted write stores mem[wr_ptr] <= i_data and increments wr_ptr.
- Read accepted iff i_inport_rd && !empty, where empty is the state before the edge. An accepted read increments rd_ptr. A read while empty is ignored with no flag.
- Simultaneous strobes:
  - Not full and not empty: both accepted; count unchanged.
  - Empty: write accepted, read ignored; count 0->1.
  - Full: read accepted, write dropped, o_overflow set; count DEPTH->DEPTH-1. Writes never bypass a full FIFO.
- o_overflow:
  - Set on any dropped write.
  - Cleared by i_clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- Head word: o_inport_data = empty ? 0 : mem[rd_ptr]. This gives first-word-fall-through, so the processor reads the data and then strobes i_inport_rd.
- Flags (o_inport_empty, o_data_full, o_data_almost_full) are combinational decodes of the pointer registers only. They have no combinational path from the strobes.

## Timing
- Reset, while i_rst_n is low:
  - wr_ptr = rd_ptr = 0.
  - o_inport_empty = 1, o_data_full = 0, o_data_almost_full = 0 (ALMOST_FULL >= 1).
  - o_count = 0, o_overflow = 0, o_inport_data = 0.
- Write latency: a write accepted at edge k makes the word visible on o_inport_data, drops o_inport_empty and raises o_count, all after edge k. That is one cycle from strobe to availability.
- Read latency: a pop at edge k advances o_inport_data to the next word, or to 0 if the FIFO becomes empty, after edge k.
- Full assertion: o_data_full rises after the edge that writes word DEPTH. It falls after the first accepted read.
- Reset mid-operation: contents are discarded and all outputs return to their reset values asynchronously. Strobes are ignored until the first edge after release.
- Pointer wrap: continuous traffic for more than 2*DEPTH words must preserve order and count exactly.

## Test plan
- Reset then idle: o_inport_empty=1, o_count=0, o_inport_data=0, o_data_full=0, o_overflow=0.
- Write 0x00..0x0F (DEPTH=16) on consecutive cycles:
  - o_data_almost_full rises after the 14th write.
  - o_data_full rises after the 16th write; o_count=16.
  - Then pop 16: data read back is 0x00..0x0F in order, and o_inport_empty=1 after the last pop.
- With the FIFO full, write 0xAA: word dropped, o_overflow=1, o_count=16.
  - Then i_clear_overflow gives o_overflow=0.
  - Assert the clear together with another dropped write: o_overflow stays 1.
- Simultaneous read and write:
  - At count 5: count stays 5.
  - Full: count becomes 15, overflow set.
  - Empty with i_data=0x3C: count 1, o_inport_data=0x3C.
- Stream 100 incrementing bytes, popping one cycle after each write: output sequence matches, the pointers wrap, and there are no full or overflow events.
- Write 3 words, drive i_rst_n low between edges: outputs return to reset values immediately, and the next write after release reads back first.
